dff_pipe_n_m_val: RTL

//  - Pipelined register bank: m lanes of n-bit data carried through D register stages.
//  - Per-stage valid bits and a valid/ready handshake with bubble collapsing.
//  - Synchronous flush and a programmable reset value per bit field.
//  - Successor to the single-stage n x m reset-value DFF bank; used to retime wide lane buses between datapath blocks under backpressure.

---
 rtl/dff_pipe_n_m_val.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dff_pipe_n_m_val.sv
// dff_pipe_n_m_val: m lanes of n-bit data retimed through D register stages.
// Each stage carries a valid bit; a combinational ready chain lets empty
// stages fill while later stages stall, so bubbles collapse.
// Reset and flush load every lane of every stage with val and clear all valids.
// Optional feature macro: DFF_PIPE_OCC_EN adds occ_o, the registered count of
// occupied stages.
module dff_pipe_n_m_val #(
    parameter int            n   = 4,
    parameter int            m   = 16,
    parameter int            D   = 2,
    parameter logic [n-1:0]  val = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [n-1:0]     In_i [0:m-1],
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [n-1:0]     In_o [0:m-1],
    output logic             out_valid_o,
    input  logic             out_ready_i
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(D+1)-1:0] occ_o
`endif
);

    if (D < 1) begin : g_depth_check
        $error("dff_pipe_n_m_val: D must be at least 1");
    end

    logic [n-1:0] data_p [0:D-1][0:m-1];
    logic [D-1:0] vld_p;
    logic [D-1:0] vld_nxt;
    logic [D-1:0] load;
    logic [D:0]   rdy;
    logic         accept;

    // Ready chain: a stage can take new data if it is empty or its occupant leaves.
    always_comb begin
        rdy    = '0;
        rdy[D] = out_ready_i;
        for (int k = D - 1; k >= 0; k--) begin
            rdy[k] = !vld_p[k] || rdy[k+1];
        end
    end

    assign in_ready_o = rdy[0] && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Per-stage load strobes and next valid state (load wins over hand-off).
    always_comb begin
        load    = '0;
        vld_nxt = vld_p;
        load[0] = accept;
        for (int k = 1; k < D; k++) begin
            load[k] = vld_p[k-1] && rdy[k];
        end
        for (int k = 0; k < D; k++) begin
            if (load[k]) begin
                vld_nxt[k] = 1'b1;
            end else if (vld_p[k] && rdy[k+1]) begin
                vld_nxt[k] = 1'b0;
            end
        end
    end

    // Valid bits: cleared by reset or flush, otherwise follow the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_p <= '0;
        end else begin
            vld_p <= vld_nxt;
        end
    end

    // Lane data: reset/flush load val; otherwise a stage only changes when loaded.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int k = 0; k < D; k++) begin
                for (int l = 0; l < m; l++) begin
                    data_p[k][l] <= val;
                end
            end
        end else begin
            if (load[0]) begin
                for (int l = 0; l < m; l++) begin
                    data_p[0][l] <= In_i[l];
                end
            end
            for (int k = 1; k < D; k++) begin
                if (load[k]) begin
                    for (int l = 0; l < m; l++) begin
                        data_p[k][l] <= data_p[k-1][l];
                    end
                end
            end
        end
    end

    assign In_o        = data_p[D-1];
    assign out_valid_o = vld_p[D-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = $clog2(D + 1);

    logic [OCC_W-1:0] occ_p;

    function automatic logic [OCC_W-1:0] popcnt(input logic [D-1:0] x);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < D; i++) begin
            if (x[i]) c = c + 1'b1;
        end
        return c;
    endfunction

    // Occupancy is registered from the same next-state as the valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            occ_p <= '0;
        end else begin
            occ_p <= popcnt(vld_nxt);
        end
    end

    assign occ_o = occ_p;
`endif

endmodule
